rrf_alloc_multi: RTL and testbench

Parametrised, multi-wide successor of the rename-register (RRF) entry allocator. Each cycle it hands out up to DISPATCH_WIDTH consecutive RRF tags to the dispatch slots that request a destination register. It reclaims up to COMMIT_WIDTH entries per cycle from the ROB commit stage. It maintains the allocation pointer, the commit (head) pointer, the free count and the wrap phase. It sits between decode/dispatch and the Arf/Rrf set-busy/allocate inputs.

---
 rtl/rrf_alloc_multi_pkg.sv | 16 +
 rtl/rrf_alloc_multi_if.sv | 39 +++
 rtl/rrf_alloc_multi_mod_add.sv | 24 ++
 rtl/rrf_alloc_multi.sv | 114 +++++++++++
 tb/tb_rrf_alloc_multi.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rrf_alloc_multi_pkg.sv
// Shared constants and types for the multi-wide RRF tag allocator.
// Optional branch rollback is enabled by defining RRF_ROLLBACK_EN.
package rrf_alloc_multi_pkg;

    localparam int RRF_NUM        = 64;
    localparam int RRF_SEL        = $clog2(RRF_NUM);
    localparam int DISPATCH_WIDTH = 2;
    localparam int COMMIT_WIDTH   = 2;
    localparam int FREE_W         = RRF_SEL + 1;
    localparam int COM_W          = $clog2(COMMIT_WIDTH + 1);
    localparam int REQ_CNT_W      = $clog2(DISPATCH_WIDTH + 1);

    typedef logic [RRF_SEL-1:0] rrftag_t;
    typedef logic [FREE_W-1:0]  freenum_t;

endpackage

// File: rtl/rrf_alloc_multi_if.sv
// Dispatch/commit handshake bundle of the RRF allocator.
// Rollback signals exist only when RRF_ROLLBACK_EN is defined.
interface rrf_alloc_multi_if;
    import rrf_alloc_multi_pkg::*;

    logic [DISPATCH_WIDTH-1:0]         alloc_req_i;
    logic                              stall_dp_i;
    logic [COM_W-1:0]                  com_inst_num_i;
    logic                              rrf_allocatable_o;
    freenum_t                          freenum_o;
    rrftag_t                           rrfptr_o;
    rrftag_t                           comptr_o;
    logic [DISPATCH_WIDTH*RRF_SEL-1:0] dst_rename_rrftag_o;
    logic                              alloc_fire_o;
    logic                              nextrrfcyc_o;
`ifdef RRF_ROLLBACK_EN
    logic                              rollback_i;
    rrftag_t                           rollback_rrftag_i;
`endif

    modport master (
        output alloc_req_i, stall_dp_i, com_inst_num_i,
`ifdef RRF_ROLLBACK_EN
        output rollback_i, rollback_rrftag_i,
`endif
        input  rrf_allocatable_o, freenum_o, rrfptr_o, comptr_o,
        input  dst_rename_rrftag_o, alloc_fire_o, nextrrfcyc_o
    );

    modport slave (
        input  alloc_req_i, stall_dp_i, com_inst_num_i,
`ifdef RRF_ROLLBACK_EN
        input  rollback_i, rollback_rrftag_i,
`endif
        output rrf_allocatable_o, freenum_o, rrfptr_o, comptr_o,
        output dst_rename_rrftag_o, alloc_fire_o, nextrrfcyc_o
    );

endinterface

// File: rtl/rrf_alloc_multi_mod_add.sv
// Modulo-RRF_NUM adder: pointer plus a small count, with wrap flag.
// A single compare-and-subtract suffices since cnt_i < RRF_NUM.
module rrf_mod_add
    import rrf_alloc_multi_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  rrftag_t          ptr_i,
    input  logic [CNT_W-1:0] cnt_i,
    output rrftag_t          sum_o,
    output logic             wrap_o
);

    localparam int W = RRF_SEL + 1;

    logic [W-1:0] raw;
    logic [W-1:0] sub;

    assign raw    = {1'b0, ptr_i} + W'(cnt_i);
    assign sub    = raw - W'(RRF_NUM);
    assign wrap_o = raw >= W'(RRF_NUM);
    assign sum_o  = wrap_o ? sub[RRF_SEL-1:0] : raw[RRF_SEL-1:0];

endmodule

// File: rtl/rrf_alloc_multi.sv
// Multi-wide RRF tag allocator: consecutive tags per dispatch slot, commit reclaim.
// Define RRF_ROLLBACK_EN to add branch-mispredict rollback of the alloc pointer.
module rrf_alloc_multi
    import rrf_alloc_multi_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    rrf_alloc_multi_if.slave bus
);

    rrftag_t  rrfptr_q, rrfptr_d;
    rrftag_t  comptr_q, comptr_d;
    freenum_t freenum_q, freenum_d;
    logic     cyc_q, cyc_d;

    logic [REQ_CNT_W-1:0] pre [DISPATCH_WIDTH+1];
    logic [REQ_CNT_W-1:0] n_alloc;
    rrftag_t              tag [DISPATCH_WIDTH];
    logic [DISPATCH_WIDTH-1:0] tag_wrap_unused;
    logic     allocatable, fire, rollback;
    rrftag_t  ptr_add;
    logic     ptr_wrap;
    logic     com_wrap_unused;

`ifdef RRF_ROLLBACK_EN
    freenum_t rb_live;
    assign rollback = bus.rollback_i;
    assign rb_live  = (bus.rollback_rrftag_i >= comptr_d)
                    ? FREE_W'(bus.rollback_rrftag_i) - FREE_W'(comptr_d)
                    : FREE_W'(bus.rollback_rrftag_i) + FREE_W'(RRF_NUM)
                      - FREE_W'(comptr_d);
`else
    assign rollback = 1'b0;
`endif

    // pre[k] = requests in slots below k; gives gap-compressed slot offsets
    always_comb begin
        pre[0] = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++)
            pre[k+1] = pre[k] + REQ_CNT_W'(bus.alloc_req_i[k]);
    end

    assign allocatable = freenum_q >= FREE_W'(DISPATCH_WIDTH);
    assign fire    = (|bus.alloc_req_i) & ~bus.stall_dp_i & allocatable
                   & ~rollback & ~reset;
    assign n_alloc = fire ? pre[DISPATCH_WIDTH] : '0;

    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_slot
        rrf_mod_add #(.CNT_W(REQ_CNT_W)) u_tag (
            .ptr_i  (rrfptr_q),
            .cnt_i  (pre[k]),
            .sum_o  (tag[k]),
            .wrap_o (tag_wrap_unused[k])
        );
        assign bus.dst_rename_rrftag_o[k*RRF_SEL +: RRF_SEL] = tag[k];
    end

    rrf_mod_add #(.CNT_W(REQ_CNT_W)) u_ptr (
        .ptr_i  (rrfptr_q),
        .cnt_i  (n_alloc),
        .sum_o  (ptr_add),
        .wrap_o (ptr_wrap)
    );

    rrf_mod_add #(.CNT_W(COM_W)) u_com (
        .ptr_i  (comptr_q),
        .cnt_i  (bus.com_inst_num_i),
        .sum_o  (comptr_d),
        .wrap_o (com_wrap_unused)
    );

    always_comb begin
        rrfptr_d  = ptr_add;
        cyc_d     = cyc_q ^ ptr_wrap;
        freenum_d = freenum_q - FREE_W'(n_alloc)
                  + FREE_W'(bus.com_inst_num_i);
`ifdef RRF_ROLLBACK_EN
        if (bus.rollback_i) begin
            rrfptr_d = bus.rollback_rrftag_i;
            cyc_d    = cyc_q ^ (bus.rollback_rrftag_i > rrfptr_q);
            // equal tag keeps the old count so a full RRF stays full
            if (bus.rollback_rrftag_i != rrfptr_q)
                freenum_d = FREE_W'(RRF_NUM) - rb_live;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrfptr_q  <= '0;
            comptr_q  <= '0;
            freenum_q <= FREE_W'(RRF_NUM);
            cyc_q     <= 1'b0;
        end else begin
            rrfptr_q  <= rrfptr_d;
            comptr_q  <= comptr_d;
            freenum_q <= freenum_d;
            cyc_q     <= cyc_d;
        end
    end

    assign bus.rrf_allocatable_o = allocatable;
    assign bus.freenum_o         = freenum_q;
    assign bus.rrfptr_o          = rrfptr_q;
    assign bus.comptr_o          = comptr_q;
    assign bus.alloc_fire_o      = fire;
    assign bus.nextrrfcyc_o      = cyc_q;

    a_com_max: assert property (@(posedge clk) disable iff (reset)
        bus.com_inst_num_i <= COM_W'(COMMIT_WIDTH));
    a_com_live: assert property (@(posedge clk) disable iff (reset)
        FREE_W'(bus.com_inst_num_i) <= FREE_W'(RRF_NUM) - freenum_q);

endmodule

// File: tb/tb_rrf_alloc_multi.sv
// Scoreboard bench for rrf_alloc_multi; rollback vectors run when
// RRF_ROLLBACK_EN is defined.
module tb_rrf_alloc_multi;
    import rrf_alloc_multi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rrf_alloc_multi_if bus ();

    rrf_alloc_multi dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string    name;
        bit       fire;
        bit       alloc;
        int       free;
        int       ptr;
        int       com;
        bit       cyc;
        bit [1:0] req;
        int       tag0;
        int       tag1;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    int m_ptr, m_com, m_free;
    bit m_cyc;

    task automatic model_reset();
        m_ptr  = 0;
        m_com  = 0;
        m_free = 64;
        m_cyc  = 0;
    endtask

    task automatic drive(bit [1:0] req, bit stall, int com,
                         bit rb, int rbtag);
        bus.alloc_req_i    = req;
        bus.stall_dp_i     = stall;
        bus.com_inst_num_i = 2'(com);
`ifdef RRF_ROLLBACK_EN
        bus.rollback_i        = rb;
        bus.rollback_rrftag_i = 6'(rbtag);
`else
        if (rb && rbtag < 0) $display("note: rollback ignored");
`endif
    endtask

    task automatic step(string name, bit [1:0] req, bit stall, int com,
                        bit rb = 0, int rbtag = 0);
        exp_t e;
        int   n;
        int   old_ptr;
        @(posedge clk);
        #1;
        drive(req, stall, com, rb, rbtag);
        e.name  = name;
        e.alloc = m_free >= 2;
        e.fire  = (req != 2'b00) && !stall && e.alloc && !rb;
        e.free  = m_free;
        e.ptr   = m_ptr;
        e.com   = m_com;
        e.cyc   = m_cyc;
        e.req   = req;
        e.tag0  = m_ptr % 64;
        e.tag1  = (m_ptr + int'(req[0])) % 64;
        q.push_back(e);
        n       = e.fire ? $countones(req) : 0;
        old_ptr = m_ptr;
        m_com   = (m_com + com) % 64;
        if (rb) begin
            if (rbtag > old_ptr) m_cyc = ~m_cyc;
            if (rbtag != old_ptr)
                m_free = 64 - ((rbtag - m_com + 64) % 64);
            else
                m_free = m_free + com;
            m_ptr = rbtag;
        end else begin
            if (m_ptr + n >= 64) m_cyc = ~m_cyc;
            m_ptr  = (m_ptr + n) % 64;
            m_free = m_free - n + com;
        end
    endtask

    // async reset lands mid-cycle while a 2-wide alloc + commit is pending
    task automatic reset_mid();
        exp_t e;
        @(posedge clk);
        #1;
        drive(2'b11, 0, 2, 0, 0);
        #2;
        reset = 1'b1;
        e.name  = "reset_mid";
        e.fire  = 0;
        e.alloc = 1;
        e.free  = 64;
        e.ptr   = 0;
        e.com   = 0;
        e.cyc   = 0;
        e.req   = 2'b11;
        e.tag0  = 0;
        e.tag1  = 1;
        q.push_back(e);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(2'b00, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.rrf_allocatable_o !== e.alloc ||
                int'(bus.freenum_o) != e.free ||
                int'(bus.rrfptr_o) != e.ptr ||
                int'(bus.comptr_o) != e.com ||
                bus.nextrrfcyc_o !== e.cyc) begin
                failures++;
                $display("FAIL %s state: got alloc=%0b free=%0d ptr=%0d com=%0d cyc=%0b want alloc=%0b free=%0d ptr=%0d com=%0d cyc=%0b",
                    e.name, bus.rrf_allocatable_o, bus.freenum_o,
                    bus.rrfptr_o, bus.comptr_o, bus.nextrrfcyc_o,
                    e.alloc, e.free, e.ptr, e.com, e.cyc);
            end
            checks++;
            if (bus.alloc_fire_o !== e.fire) begin
                failures++;
                $display("FAIL %s fire: got %0b want %0b",
                    e.name, bus.alloc_fire_o, e.fire);
            end
            if (e.fire && e.req[0]) begin
                checks++;
                if (int'(bus.dst_rename_rrftag_o[5:0]) != e.tag0) begin
                    failures++;
                    $display("FAIL %s tag0: got %0d want %0d",
                        e.name, bus.dst_rename_rrftag_o[5:0], e.tag0);
                end
            end
            if (e.fire && e.req[1]) begin
                checks++;
                if (int'(bus.dst_rename_rrftag_o[11:6]) != e.tag1) begin
                    failures++;
                    $display("FAIL %s tag1: got %0d want %0d",
                        e.name, bus.dst_rename_rrftag_o[11:6], e.tag1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(2'b00, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        step("reset_state", 2'b00, 0, 0);
        step("alloc_11", 2'b11, 0, 0);
        step("alloc_10", 2'b10, 0, 0);
        step("alloc_01", 2'b01, 0, 0);
        while (m_free >= 2) step("fill", 2'b11, 0, 0);
        step("full_ignore", 2'b01, 0, 0);
        step("commit2", 2'b00, 0, 2);
        step("wrap", 2'b11, 0, 0);
        step("post_wrap", 2'b00, 0, 2);
        step("stall", 2'b11, 1, 0);
        step("simul", 2'b11, 0, 2);
        step("simul_chk", 2'b10, 0, 1);
        step("gap_chk", 2'b00, 0, 0);
        reset_mid();
        step("after_reset", 2'b00, 0, 0);

`ifdef RRF_ROLLBACK_EN
        repeat (5) step("rb_fill", 2'b11, 0, 0);
        step("rb_com", 2'b00, 0, 2);
        step("rb_com", 2'b00, 0, 2);
        step("rb_to6", 2'b11, 0, 0, 1, 6);
        step("rb_same", 2'b00, 0, 0, 1, 6);
        step("rb_chk", 2'b00, 0, 0);
        step("rb_alloc", 2'b11, 0, 0);
        step("rb_end", 2'b00, 0, 0);
`endif

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
